// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: pops PS/2 scan bytes from the receiver FIFO, decodes F0/E0 prefixes and emits de-duplicated key events.
// Optional feature macro: PS2_SCAN_CTRL_EXT_EN (E0 extended-key tracking; otherwise E0 is an ordinary code).
module ps2_scan_ctrl #(
    parameter int CNT_W       = 8,
    parameter int PFX_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kbd_ready,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_break,
    output logic             evt_ext,
    output logic             held,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_POP    = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;
    localparam logic [1:0] ST_EMIT   = 2'd3;

    localparam logic [7:0] CODE_BRK = 8'hF0;
`ifdef PS2_SCAN_CTRL_EXT_EN
    localparam logic [7:0] CODE_EXT = 8'hE0;
`endif

    localparam int TMR_W = (PFX_TIMEOUT > 1) ? $clog2(PFX_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((PFX_TIMEOUT > 0) ? PFX_TIMEOUT - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             held_q, held_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             ovf_q, ovf_d;
    logic             evt_valid_q, evt_valid_d;
    logic [7:0]       evt_code_q, evt_code_d;
    logic             evt_break_q, evt_break_d;
    logic             evt_ext_q, evt_ext_d;
    logic             same_key;

    assign same_key = held_q && (held_code_q == byte_q) && (held_ext_q == ext_q);

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        timer_d     = timer_q;
        held_d      = held_q;
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        press_cnt_d = press_cnt_q;
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        evt_break_d = evt_break_q;
        evt_ext_d   = evt_ext_q;
        ovf_d       = kbd_overflow ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

        case (state_q)
            ST_IDLE: begin
                // A prefix left dangling by a lost byte expires so it cannot corrupt the next key.
                if ((PFX_TIMEOUT != 0) && (brk_q || ext_q)) begin
                    if (timer_q == TMR_LAST) begin
                        brk_d   = 1'b0;
                        ext_d   = 1'b0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                if (kbd_ready && !evt_valid_q) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                byte_d  = kbd_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (byte_q == CODE_BRK) begin
                    brk_d   = 1'b1;
                    timer_d = '0;
`ifdef PS2_SCAN_CTRL_EXT_EN
                end else if (byte_q == CODE_EXT) begin
                    ext_d   = 1'b1;
                    timer_d = '0;
`endif
                end else begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                    if (brk_q) begin
                        evt_valid_d = 1'b1;
                        evt_code_d  = byte_q;
                        evt_break_d = 1'b1;
                        evt_ext_d   = ext_q;
                        state_d     = ST_EMIT;
                        if (same_key) begin
                            held_d = 1'b0;
                        end
                    end else if (!same_key) begin
                        evt_valid_d = 1'b1;
                        evt_code_d  = byte_q;
                        evt_break_d = 1'b0;
                        evt_ext_d   = ext_q;
                        state_d     = ST_EMIT;
                        held_d      = 1'b1;
                        held_code_d = byte_q;
                        held_ext_d  = ext_q;
                        press_cnt_d = press_cnt_q + 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_q      <= 8'h00;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            timer_q     <= '0;
            held_q      <= 1'b0;
            held_code_q <= 8'h00;
            held_ext_q  <= 1'b0;
            press_cnt_q <= '0;
            ovf_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 8'h00;
            evt_break_q <= 1'b0;
            evt_ext_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            timer_q     <= timer_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
            held_ext_q  <= held_ext_d;
            press_cnt_q <= press_cnt_d;
            ovf_q       <= ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            evt_break_q <= evt_break_d;
            evt_ext_q   <= evt_ext_d;
        end
    end

    assign kbd_nextdata_n = (state_q != ST_POP);
    assign evt_valid      = evt_valid_q;
    assign evt_code       = evt_code_q;
    assign evt_break      = evt_break_q;
    assign evt_ext        = evt_ext_q;
    assign held           = held_q;
    assign held_code      = held_code_q;
    assign press_cnt      = press_cnt_q;
    assign ovf_sticky     = ovf_q;

endmodule
